// File: rtl/cmp_pkg.sv
// Shared definitions for the signed comparison datapath.
package cmp_pkg;

   localparam int DEFAULT_WIDTH = 8;

   // Sign-extends the low w bits of x (1 <= w <= 32) to 33 bits; callers truncate to WIDTH+1.
   function automatic logic [32:0] sext(input logic [31:0] x, input int unsigned w);
      logic signed [32:0] t;
      t = $signed({1'b0, x}) <<< (33 - w);
      return t >>> (33 - w);
   endfunction

endpackage

// File: rtl/signed_subtractor.sv
// Combinational WIDTH+1 bit signed difference a - b with a zero flag; never overflows.
module signed_subtractor
   import cmp_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH:0]   diff_o,
   output logic             zero_o
);

   logic [WIDTH:0] a_ext;
   logic [WIDTH:0] b_ext;

   always_comb begin
      a_ext  = (WIDTH+1)'(sext(32'(a_i), WIDTH));
      b_ext  = (WIDTH+1)'(sext(32'(b_i), WIDTH));
      diff_o = a_ext - b_ext;
      zero_o = (diff_o == '0);
   end

endmodule

// File: rtl/comparator.sv
// Registered signed comparator: Sign = DOut2 < DOut1, Eq = DOut2 == DOut1, Diff = DOut2 - DOut1.
module comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] DOut2,
   input  logic [WIDTH-1:0] DOut1,
   output logic             Sign,
   output logic             Eq,
   output logic [WIDTH:0]   Diff
);

   logic [WIDTH:0] diff_d;
   logic           eq_d;
   logic           sign_d;
   logic [WIDTH:0] diff_q;
   logic           eq_q;
   logic           sign_q;

   signed_subtractor #(
      .WIDTH (WIDTH)
   ) u_sub (
      .a_i    (DOut2),
      .b_i    (DOut1),
      .diff_o (diff_d),
      .zero_o (eq_d)
   );

   // The MSB of the extended difference is exact even where a WIDTH-bit subtract would overflow.
   assign sign_d = diff_d[WIDTH];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sign_q <= 1'b0;
         eq_q   <= 1'b0;
         diff_q <= '0;
      end else begin
         sign_q <= sign_d;
         eq_q   <= eq_d;
         diff_q <= diff_d;
      end
   end

   assign Sign = sign_q;
   assign Eq   = eq_q;
   assign Diff = diff_q;

endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench for comparator (WIDTH = 8): directed test-plan vectors plus random ones.
module tb_comparator;

   localparam int W = 8;

   typedef struct {
      logic         sign;
      logic         eq;
      logic [W:0]   diff;
      string        name;
   } exp_t;

   logic         Clk = 1'b0;
   logic         Reset = 1'b1;
   logic [W-1:0] DOut2 = '0;
   logic [W-1:0] DOut1 = '0;
   logic         Sign;
   logic         Eq;
   logic [W:0]   Diff;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   comparator #(.WIDTH(W)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .DOut2 (DOut2),
      .DOut1 (DOut1),
      .Sign  (Sign),
      .Eq    (Eq),
      .Diff  (Diff)
   );

   always #5 Clk = ~Clk;

   // Reference: plain integer arithmetic on the signed operand values.
   task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic rst, input string name);
      exp_t e;
      int   av;
      int   bv;
      @(negedge Clk);
      DOut2 = a;
      DOut1 = b;
      Reset = rst;
      av = int'($signed(a));
      bv = int'($signed(b));
      e.name = name;
      if (rst) begin
         e.sign = 1'b0;
         e.eq   = 1'b0;
         e.diff = '0;
      end else begin
         e.sign = (av < bv);
         e.eq   = (av == bv);
         e.diff = (W+1)'(av - bv);
      end
      exp_q.push_back(e);
   endtask

   // Monitor: every edge presents one result, checked 1 time unit after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (Sign !== e.sign || Eq !== e.eq || Diff !== e.diff) begin
               miscompares++;
               $display("FAIL %s: got Sign=%b Eq=%b Diff=%h, expected Sign=%b Eq=%b Diff=%h",
                        e.name, Sign, Eq, Diff, e.sign, e.eq, e.diff);
            end else begin
               $display("ok   %s: Sign=%b Eq=%b Diff=%h", e.name, Sign, Eq, Diff);
            end
         end
      end
   end

   initial begin
      int   budget;
      logic rst;
      apply(8'h55, 8'h12, 1'b1, "reset0");
      apply(8'h80, 8'h7F, 1'b1, "reset1");
      apply(8'h00, 8'h00, 1'b0, "zero_eq");
      apply(8'h7F, 8'h01, 1'b0, "pos_pos");
      apply(8'h7F, 8'h80, 1'b0, "ovf_127_m128");
      apply(8'h80, 8'hFF, 1'b0, "m128_m1");
      apply(8'hFF, 8'h80, 1'b0, "m1_m128");
      apply(8'h80, 8'h7F, 1'b0, "m128_127");
      apply(8'h05, 8'hFB, 1'b0, "pos_neg");
      apply(8'hFB, 8'h05, 1'b0, "neg_pos");
      apply(8'h80, 8'h80, 1'b0, "eq_min");
      // Back-to-back stream with reset asserted on its third cycle.
      apply(8'h10, 8'h20, 1'b0, "b2b_c1");
      apply(8'hF0, 8'h0F, 1'b0, "b2b_c2");
      apply(8'h33, 8'h33, 1'b1, "b2b_c3_reset");
      apply(8'h7F, 8'h80, 1'b0, "b2b_c4");
      apply(8'h81, 8'h7F, 1'b0, "b2b_c5");
      for (int i = 0; i < 200; i++) begin
         rst = ($urandom_range(0, 19) == 0);
         apply(W'($urandom), W'($urandom), rst, $sformatf("rand%0d", i));
      end
      @(negedge Clk);
      Reset = 1'b0;
      budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge Clk);
         budget--;
      end
      #2;
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
